dot_tracker: RTL

Owns the live pellet state of the maze. Loads a per-level 12×12 dot map from ROM, clears a dot when Pac-Man's centre enters its eat window, and maintains score, remaining-dot count and level-clear status. It sits directly upstream of the colour mapper, which consumes `currDotMap` bit-for-bit (bit index = row*12 + col, 32-pixel cells, 32-pixel origin).

---
 rtl/dot_pkg.sv | 39 +++
 rtl/dot_map_rom.sv | 43 ++++
 rtl/dot_tracker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// Shared definitions for the pellet tracker: maze geometry, tracker state
// encoding, power-pellet cell indices and small bit-counting helpers.
package dot_pkg;

    localparam int MAZE_COLS  = 12;
    localparam int MAZE_ROWS  = 12;
    localparam int CELL_SHIFT = 5;
    localparam int MAZE_ORG   = 32;

    // Map indices (row*12 + col) of the four corner power pellets
    localparam logic [7:0] PELLET_IDX_0 = 8'd0;
    localparam logic [7:0] PELLET_IDX_1 = 8'd11;
    localparam logic [7:0] PELLET_IDX_2 = 8'd132;
    localparam logic [7:0] PELLET_IDX_3 = 8'd143;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_CLEAR = 2'd3
    } dot_state_t;

    // Number of dots in one 12-cell ROM row
    function automatic logic [3:0] popcount12(input logic [11:0] bits);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 12; i++) begin
            cnt = cnt + {3'd0, bits[i]};
        end
        return cnt;
    endfunction

    // True when a map index is one of the corner power pellets
    function automatic logic is_pellet(input logic [7:0] idx);
        return (idx == PELLET_IDX_0) || (idx == PELLET_IDX_1) ||
               (idx == PELLET_IDX_2) || (idx == PELLET_IDX_3);
    endfunction

endpackage

// File: rtl/dot_map_rom.sv
// Per-level dot map ROM. One 12-bit row per lookup, bit c = column c.
//   level 0: every cell holds a dot
//   level 1: a single dot at row 5, column 7
//   level 2: diagonal stripes ((row+col) % 3 != 0) plus the four corners
//   level 3: empty maze
module dot_map_rom (
    input  logic [1:0]  level,
    input  logic [3:0]  row,
    output logic [11:0] row_bits
);

    // Row pattern lookup
    always_comb begin
        row_bits = 12'h000;
        case (level)
            2'd0: begin
                if (row < 4'd12) begin
                    row_bits = 12'hFFF;
                end else begin
                    row_bits = 12'h000;
                end
            end
            2'd1: begin
                if (row == 4'd5) begin
                    row_bits = 12'h080;
                end else begin
                    row_bits = 12'h000;
                end
            end
            2'd2: begin
                case (row)
                    4'd0:                         row_bits = 12'hDB7;
                    4'd1, 4'd4, 4'd7, 4'd10:      row_bits = 12'h6DB;
                    4'd2, 4'd5, 4'd8, 4'd11:      row_bits = 12'hB6D;
                    4'd3, 4'd6, 4'd9:             row_bits = 12'hDB6;
                    default:                      row_bits = 12'h000;
                endcase
            end
            default: row_bits = 12'h000;
        endcase
    end

endmodule

// File: rtl/dot_tracker.sv
// Live pellet state of the maze: loads the level map from ROM, clears dots
// as Pac-Man's centre enters a cell's eat window, and keeps score, the
// remaining-dot count and level-clear status.
// Optional feature macro: DOT_POWER_PELLET_EN (corner power pellets and
// the frightened-mode timer behind power_active).
module dot_tracker
    import dot_pkg::*;
#(
    parameter int EAT_WIN       = 3,
    parameter int DOT_POINTS    = 10,
    parameter int PELLET_POINTS = 50,
    parameter int POWER_FRAMES  = 360
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_tick,
    input  logic         level_start,
    input  logic [1:0]   level,
    input  logic [9:0]   BallX,
    input  logic [9:0]   BallY,
    output logic [143:0] currDotMap,
    output logic [7:0]   dots_left,
    output logic [15:0]  score,
    output logic         eat_pulse,
    output logic         level_clear,
    output logic         power_active
);

    dot_state_t     state_r;
    logic [3:0]     row_r;
    logic [1:0]     level_r;
    logic [143:0]   map_r;
    logic [7:0]     dots_left_r;
    logic [15:0]    score_r;
    logic           eat_pulse_r;
    logic           level_clear_r;

    logic [11:0]    rom_row_s;
    logic [3:0]     row_pop_s;
    logic [7:0]     load_sum_s;
    logic [7:0]     row_base_s;
    logic [9:0]     dx_s;
    logic [9:0]     dy_s;
    logic [4:0]     col_s;
    logic [4:0]     row_s;
    logic           in_win_s;
    logic [7:0]     idx_s;
    logic           hit_s;
    logic           eat_s;
    logic           pellet_s;
    logic [15:0]    points_s;
    logic [16:0]    score_sum_s;
    logic [15:0]    score_nxt_s;

    dot_map_rom u_rom (
        .level    (level_r),
        .row      (row_r),
        .row_bits (rom_row_s)
    );

    // Load-side arithmetic: dots in the current ROM row and its map offset
    always_comb begin
        row_pop_s  = popcount12(rom_row_s);
        load_sum_s = dots_left_r + {4'd0, row_pop_s};
        row_base_s = {4'd0, row_r} * 8'(MAZE_COLS);
    end

    // Map Pac-Man's centre to a cell and decide whether this frame eats a dot
    always_comb begin
        dx_s     = BallX + 10'd2 - 10'(MAZE_ORG);
        dy_s     = BallY + 10'd2 - 10'(MAZE_ORG);
        col_s    = dx_s[9:CELL_SHIFT];
        row_s    = dy_s[9:CELL_SHIFT];
        in_win_s = (col_s < 5'(MAZE_COLS)) && (row_s < 5'(MAZE_ROWS)) &&
                   (dx_s[CELL_SHIFT-1:0] <= 5'(EAT_WIN)) &&
                   (dy_s[CELL_SHIFT-1:0] <= 5'(EAT_WIN));
        idx_s    = {4'd0, row_s[3:0]} * 8'(MAZE_COLS) + {4'd0, col_s[3:0]};
        if (in_win_s) begin
            hit_s = map_r[idx_s];
        end else begin
            hit_s = 1'b0;
        end
        // A new level request wins over an eat on the same edge
        eat_s = hit_s && frame_tick && !level_start && (state_r == ST_PLAY);
    end

`ifdef DOT_POWER_PELLET_EN
    assign pellet_s = is_pellet(idx_s);
`else
    assign pellet_s = 1'b0;
`endif

    // Points for this eat, with the score saturating at all ones
    always_comb begin
        if (pellet_s) begin
            points_s = 16'(PELLET_POINTS);
        end else begin
            points_s = 16'(DOT_POINTS);
        end
        score_sum_s = {1'b0, score_r} + {1'b0, points_s};
        if (score_sum_s[16]) begin
            score_nxt_s = 16'hFFFF;
        end else begin
            score_nxt_s = score_sum_s[15:0];
        end
    end

    // Level FSM: map load, dot eating, score and level-clear bookkeeping
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r       <= ST_IDLE;
            row_r         <= 4'd0;
            level_r       <= 2'd0;
            map_r         <= 144'd0;
            dots_left_r   <= 8'd0;
            score_r       <= 16'd0;
            eat_pulse_r   <= 1'b0;
            level_clear_r <= 1'b0;
        end else begin
            eat_pulse_r <= 1'b0;
            if (level_start) begin
                state_r       <= ST_LOAD;
                row_r         <= 4'd0;
                level_r       <= level;
                map_r         <= 144'd0;
                dots_left_r   <= 8'd0;
                level_clear_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_LOAD: begin
                        map_r[row_base_s +: 12] <= rom_row_s;
                        dots_left_r             <= load_sum_s;
                        if (row_r == 4'(MAZE_ROWS - 1)) begin
                            row_r <= 4'd0;
                            if (load_sum_s == 8'd0) begin
                                state_r       <= ST_CLEAR;
                                level_clear_r <= 1'b1;
                            end else begin
                                state_r <= ST_PLAY;
                            end
                        end else begin
                            row_r <= row_r + 4'd1;
                        end
                    end
                    ST_PLAY: begin
                        if (eat_s) begin
                            map_r[idx_s] <= 1'b0;
                            dots_left_r  <= dots_left_r - 8'd1;
                            score_r      <= score_nxt_s;
                            eat_pulse_r  <= 1'b1;
                            if (dots_left_r == 8'd1) begin
                                state_r       <= ST_CLEAR;
                                level_clear_r <= 1'b1;
                            end else begin
                                state_r <= ST_PLAY;
                            end
                        end else begin
                            state_r <= ST_PLAY;
                        end
                    end
                    ST_CLEAR: begin
                        state_r <= ST_CLEAR;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DOT_POWER_PELLET_EN
    logic [8:0] timer_r;
    logic [8:0] timer_nxt_s;
    logic       power_r;

    // Frightened timer: reload on a pellet eat, count frames down otherwise
    always_comb begin
        if (level_start || (state_r == ST_LOAD)) begin
            timer_nxt_s = 9'd0;
        end else if (eat_s && pellet_s) begin
            timer_nxt_s = 9'(POWER_FRAMES);
        end else if (frame_tick && (timer_r != 9'd0) &&
                     ((state_r == ST_PLAY) || (state_r == ST_CLEAR))) begin
            timer_nxt_s = timer_r - 9'd1;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Timer and its registered nonzero flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timer_r <= 9'd0;
            power_r <= 1'b0;
        end else begin
            timer_r <= timer_nxt_s;
            power_r <= (timer_nxt_s != 9'd0);
        end
    end

    assign power_active = power_r;
`else
    logic [8:0] unused_power_frames_s;
    assign unused_power_frames_s = 9'(POWER_FRAMES);
    assign power_active          = 1'b0;
`endif

    assign currDotMap  = map_r;
    assign dots_left   = dots_left_r;
    assign score       = score_r;
    assign eat_pulse   = eat_pulse_r;
    assign level_clear = level_clear_r;

endmodule
